// File: rtl/conv_pkg.sv
// conv_pkg: shared state type and frame sizes for the 3x3 Laplacian
// datapath and its frame sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } conv_seq_state_t;

  localparam int CONV_INPUT_SIZE  = 16;
  localparam int CONV_OUTPUT_SIZE = CONV_INPUT_SIZE - 2;

  function automatic int cnt_width(input int n);
    return $clog2(n * n + 1);
  endfunction

  localparam int CONV_PIX_CNT_W = cnt_width(CONV_INPUT_SIZE);
  localparam int CONV_RES_CNT_W = cnt_width(CONV_OUTPUT_SIZE);

endpackage

// File: rtl/frame_coord_counter.sv
// frame_coord_counter: row/col raster counter over an EDGE x EDGE frame,
// with a linear count that flags the final position.
module frame_coord_counter
  import conv_pkg::*;
#(
  parameter int EDGE = CONV_INPUT_SIZE,
  parameter int CW   = CONV_PIX_CNT_W,
  parameter int RW   = $clog2(EDGE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          last
);

  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
      if (col_q == RW'(EDGE - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (cnt_q == CW'(EDGE * EDGE - 1));

endmodule

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: frame control for the 3x3 Laplacian datapath.
// Optional drain watchdog is built when CONV_SEQ_TIMEOUT_EN is defined.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int INPUT_SIZE     = CONV_INPUT_SIZE,
  parameter int OUTPUT_SIZE    = CONV_OUTPUT_SIZE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic                           stage1_en,
  output logic                           dp_reset,
  input  logic                           conv_valid,
  output logic                           out_valid,
  output logic [$clog2(OUTPUT_SIZE)-1:0] out_row,
  output logic [$clog2(OUTPUT_SIZE)-1:0] out_col,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           err_timeout
);

  localparam int IW = $clog2(INPUT_SIZE);
  localparam int OW = $clog2(OUTPUT_SIZE);

  conv_seq_state_t state_q, state_d;

  logic          pix_ready_q, pix_ready_d;
  logic          dp_reset_q, dp_reset_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_row_q, out_row_d;
  logic [OW-1:0] out_col_q, out_col_d;

  logic          clr;
  logic          counting;
  logic          pix_en;
  logic          res_en;
  logic          pix_last;
  logic          res_last;
  logic          wd_hit;
  logic [IW-1:0] pix_row;
  logic [IW-1:0] pix_col;
  logic [OW-1:0] res_row;
  logic [OW-1:0] res_col;
  logic          unused_pix;

  assign clr      = (state_q == S_CLEAR);
  assign counting = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign pix_en   = pix_valid & pix_ready_q;
  assign res_en   = conv_valid & counting;

  frame_coord_counter #(
    .EDGE (INPUT_SIZE),
    .CW   (cnt_width(INPUT_SIZE)),
    .RW   (IW)
  ) u_pix_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (pix_en),
    .row   (pix_row),
    .col   (pix_col),
    .last  (pix_last)
  );

  frame_coord_counter #(
    .EDGE (OUTPUT_SIZE),
    .CW   (cnt_width(OUTPUT_SIZE)),
    .RW   (OW)
  ) u_res_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (res_en),
    .row   (res_row),
    .col   (res_col),
    .last  (res_last)
  );

  // input coordinates are tracked for the datapath but not exported
  assign unused_pix = ^{pix_row, pix_col};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (res_en && res_last) state_d = S_DONE;
        else if (pix_en && pix_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((res_en && res_last) || wd_hit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready_d = (state_d == S_LOAD);
    dp_reset_d  = (state_d != S_CLEAR);
    out_valid_d = res_en;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (clr) begin
      out_row_d = '0;
      out_col_d = '0;
    end else if (res_en) begin
      out_row_d = res_row;
      out_col_d = res_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pix_ready_q <= 1'b0;
      dp_reset_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      pix_ready_q <= pix_ready_d;
      dp_reset_q  <= dp_reset_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // counts DRAIN cycles since the most recent result strobe
  always_comb begin
    wd_d   = '0;
    wd_hit = 1'b0;
    err_d  = err_q;
    if (state_q == S_DRAIN && !conv_valid) begin
      wd_d   = wd_q + WW'(1);
      wd_hit = (wd_d == WW'(TIMEOUT_CYCLES));
    end
    if (clr) err_d = 1'b0;
    else if (wd_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;

  assign wd_hit         = 1'b0;
  assign err_timeout    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign pix_ready  = pix_ready_q;
  assign stage1_en  = pix_en;
  assign dp_reset   = dp_reset_q;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: randomized frame runs checked every cycle
// against a model built from pixel/result counts and frame phases.
module tb_conv_frame_sequencer;

  localparam int IS = 16;
  localparam int OS = 14;
  localparam int TO = 8;
`ifdef CONV_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_LOAD  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, pix_valid, conv_valid;
  logic       pix_ready, stage1_en, dp_reset, out_valid;
  logic       busy, frame_done, err_timeout;
  logic [3:0] out_row, out_col;
  logic [13:0] dut_bus;

  int total = 0;
  int bad   = 0;

  int     m_ph  = P_IDLE;
  int     m_pix = 0;
  int     m_res = 0;
  int     m_wd  = 0;
  bit     m_inrst = 1'b1;
  bit     m_ov  = 1'b0;
  bit     m_err = 1'b0;
  bit [3:0] m_row = '0;
  bit [3:0] m_col = '0;

  always #5 clk = ~clk;

  conv_frame_sequencer #(
    .INPUT_SIZE     (IS),
    .OUTPUT_SIZE    (OS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .stage1_en   (stage1_en),
    .dp_reset    (dp_reset),
    .conv_valid  (conv_valid),
    .out_valid   (out_valid),
    .out_row     (out_row),
    .out_col     (out_col),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  assign dut_bus = {pix_ready, busy, frame_done, dp_reset, out_valid,
                    out_row, out_col, err_timeout};

  // one rising edge of the reference behaviour
  task automatic model_step();
    m_ov = 1'b0;
    if (!rst_n) begin
      m_ph = P_IDLE; m_pix = 0; m_res = 0; m_wd = 0;
      m_row = '0; m_col = '0; m_err = 1'b0; m_inrst = 1'b1;
      return;
    end
    m_inrst = 1'b0;
    case (m_ph)
      P_IDLE: if (start) m_ph = P_CLEAR;
      P_CLEAR: begin
        m_pix = 0; m_res = 0; m_wd = 0;
        m_row = '0; m_col = '0; m_err = 1'b0;
        m_ph = P_LOAD;
      end
      P_LOAD, P_DRAIN: begin
        if (m_ph == P_LOAD && pix_valid) m_pix++;
        if (conv_valid) begin
          m_row = 4'(m_res / OS);
          m_col = 4'(m_res % OS);
          m_res++;
          m_ov = 1'b1;
          m_wd = 0;
        end else if (m_ph == P_DRAIN) begin
          m_wd++;
        end
        if (m_res == OS * OS) m_ph = P_DONE;
        else if (m_ph == P_LOAD && m_pix == IS * IS) m_ph = P_DRAIN;
        else if (m_ph == P_DRAIN && TO_EN && m_wd == TO) begin
          m_ph = P_DONE;
          m_err = 1'b1;
        end
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  function automatic logic [13:0] exp_bus();
    return {m_ph == P_LOAD, m_ph != P_IDLE, m_ph == P_DONE,
            !m_inrst && m_ph != P_CLEAR, m_ov, m_row, m_col,
            TO_EN && m_err};
  endfunction

  function automatic bit cv_pick(input int load_pct);
    if (m_ph == P_LOAD) return m_pix >= 34 && $urandom_range(99) < load_pct;
    if (m_ph == P_DRAIN) return $urandom_range(99) < 75;
    return $urandom_range(1) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input bit st, input bit pv, input bit cv,
                      output bit s1, output bit s1_exp);
    start = st; pix_valid = pv; conv_valid = cv;
    #1;
    s1 = stage1_en;
    s1_exp = pv && (m_ph == P_LOAD);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b1; conv_valid = 1'b1;
    tick(); tick();
    total++;
    if (dut_bus !== exp_bus()) begin
      bad++; $display("FAIL reset_vals got=%h exp=%h", dut_bus, exp_bus());
    end
    total++;
    if (stage1_en !== 1'b0) begin
      bad++; $display("FAIL reset_stage1 got=%b exp=0", stage1_en);
    end
    rst_n = 1'b1; pix_valid = 1'b0; conv_valid = 1'b0;
    tick();
    total++;
    if (dp_reset !== 1'b1) begin
      bad++; $display("FAIL reset_dp_release got=%b exp=1", dp_reset);
    end
  endtask

  task automatic test_full_frame();
    int xfer = 0; int nres = 0; bit fin = 0; bit s1, s1e;
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    for (int c = 0; c < 3000 && !fin; c++) begin
      step(1'b0, 1'b1, cv_pick(50), s1, s1e);
      total++;
      if (s1 !== s1e) begin
        bad++; $display("FAIL full_stage1 got=%b exp=%b", s1, s1e);
      end
      total++;
      if (dut_bus !== exp_bus()) begin
        bad++; $display("FAIL full_bus got=%h exp=%h", dut_bus, exp_bus());
      end
      xfer += int'(s1);
      nres += int'(out_valid === 1'b1);
      if (m_ph == P_DONE) fin = 1'b1;
    end
    total++;
    if (!fin || frame_done !== 1'b1) begin
      bad++; $display("FAIL full_done got=%b exp=1", frame_done);
    end
    total++;
    if (xfer != IS * IS) begin
      bad++; $display("FAIL full_xfer got=%0d exp=%0d", xfer, IS * IS);
    end
    total++;
    if (nres != OS * OS) begin
      bad++; $display("FAIL full_results got=%0d exp=%0d", nres, OS * OS);
    end
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL full_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_toggle();
    int xfer = 0; bit fin = 0; bit pv = 0; bit s1, s1e;
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    for (int c = 0; c < 3000 && !fin; c++) begin
      pv = ~pv;
      step(1'b0, pv, cv_pick(25), s1, s1e);
      total++;
      if (s1 !== s1e) begin
        bad++; $display("FAIL toggle_stage1 got=%b exp=%b", s1, s1e);
      end
      total++;
      if (dut_bus !== exp_bus()) begin
        bad++; $display("FAIL toggle_bus got=%h exp=%h", dut_bus, exp_bus());
      end
      xfer += int'(s1);
      if (m_ph == P_DONE) fin = 1'b1;
    end
    total++;
    if (!fin || xfer != IS * IS) begin
      bad++; $display("FAIL toggle_xfer got=%0d exp=%0d", xfer, IS * IS);
    end
    total++;
    if (out_row !== 4'd13 || out_col !== 4'd13) begin
      bad++; $display("FAIL toggle_last_coord got=%0d/%0d exp=13/13",
                      out_row, out_col);
    end
    step(1'b0, 1'b0, 1'b0, s1, s1e);
  endtask

  task automatic test_start_ignored();
    bit fin = 0; bit st; bit s1, s1e; int lows = 0;
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    for (int c = 0; c < 3000 && !fin; c++) begin
      st = (m_ph == P_LOAD || m_ph == P_DRAIN) && $urandom_range(7) == 0;
      step(st, 1'b1, cv_pick(50), s1, s1e);
      total++;
      if (dut_bus !== exp_bus()) begin
        bad++; $display("FAIL start_ign_bus got=%h exp=%h", dut_bus, exp_bus());
      end
      if (m_ph == P_DONE) fin = 1'b1;
    end
    total++;
    if (!fin || m_res != OS * OS || frame_done !== 1'b1) begin
      bad++; $display("FAIL start_ign_done got=%b exp=1", frame_done);
    end
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    lows += int'(dp_reset === 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b0, s1, s1e);
      lows += int'(dp_reset === 1'b0);
    end
    total++;
    if (lows != 1) begin
      bad++; $display("FAIL start_dp_pulse got=%0d exp=1", lows);
    end
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, s1, s1e);
  endtask

  task automatic test_mid_reset();
    bit s1, s1e; bit fin = 0; int xfer = 0;
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    for (int c = 0; c < 400 && m_pix < 100; c++)
      step(1'b0, $urandom_range(3) != 0, cv_pick(50), s1, s1e);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1, s1, s1e);
    total++;
    if (dut_bus !== 14'h0 || m_pix != 0) begin
      bad++; $display("FAIL midrst_vals got=%h exp=0", dut_bus);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    for (int c = 0; c < 3000 && !fin; c++) begin
      step(1'b0, 1'b1, cv_pick(50), s1, s1e);
      total++;
      if (dut_bus !== exp_bus()) begin
        bad++; $display("FAIL midrst_bus got=%h exp=%h", dut_bus, exp_bus());
      end
      xfer += int'(s1);
      if (m_ph == P_DONE) fin = 1'b1;
    end
    total++;
    if (!fin || xfer != IS * IS) begin
      bad++; $display("FAIL midrst_xfer got=%0d exp=%0d", xfer, IS * IS);
    end
    step(1'b0, 1'b0, 1'b0, s1, s1e);
  endtask

  task automatic test_same_cycle();
    bit s1, s1e;
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    for (int k = 0; k < IS * IS; k++) begin
      step(1'b0, 1'b1, k >= IS * IS - OS * OS, s1, s1e);
      total++;
      if (dut_bus !== exp_bus()) begin
        bad++; $display("FAIL same_bus k=%0d got=%h exp=%h", k, dut_bus, exp_bus());
      end
    end
    total++;
    if (frame_done !== 1'b1 || pix_ready !== 1'b0) begin
      bad++; $display("FAIL same_done got=%b exp=1", frame_done);
    end
    total++;
    if (out_row !== 4'd13 || out_col !== 4'd13) begin
      bad++; $display("FAIL same_coord got=%0d/%0d exp=13/13", out_row, out_col);
    end
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL same_idle busy got=%b exp=0", busy);
    end
  endtask

`ifdef CONV_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit s1, s1e; bit fin = 0; bit cv; int stall = 0;
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    for (int c = 0; c < 3000 && !fin; c++) begin
      cv = cv_pick(50) && m_res < 150;
      if (cv) stall = 0;
      else if (m_ph == P_DRAIN) stall++;
      step(1'b0, 1'b1, cv, s1, s1e);
      total++;
      if (dut_bus !== exp_bus()) begin
        bad++; $display("FAIL tmo_bus got=%h exp=%h", dut_bus, exp_bus());
      end
      if (frame_done === 1'b1 || m_ph == P_DONE) fin = 1'b1;
    end
    total++;
    if (err_timeout !== 1'b1 || frame_done !== 1'b1 || stall != TO) begin
      bad++; $display("FAIL tmo_flag err=%b done=%b stall=%0d exp=1/1/%0d",
                      err_timeout, frame_done, stall, TO);
    end
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    step(1'b1, 1'b0, 1'b0, s1, s1e);
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    total++;
    if (err_timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_clear got=%b exp=0", err_timeout);
    end
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, s1, s1e);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, s1, s1e);
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; conv_valid = 1'b0;
    test_reset();
    test_full_frame();
    test_toggle();
    test_start_ignored();
    test_mid_reset();
    test_same_cycle();
`ifdef CONV_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
